// File: rtl/kulisch_dot_ctrl.sv
// kulisch_dot_ctrl
//   Sequences one shared fp16 Booth mantissa multiplier through a dot product
//   of cfg_len operand pairs. Operand pairs arrive under valid/ready and are
//   passed straight to the multiplier. The product terms (sign, sum, carry,
//   exponent) are captured in a one-deep output register that feeds the
//   Kulisch accumulator under valid/ready. The block pulses acc_clear at the
//   start of a run and done at its end, and reports the pair count and the
//   sticky multiplier exception.
//
//   Ports
//     CLK, RST               clock, synchronous active-high reset
//     start, cfg_len         begin a run of cfg_len pairs (sampled in IDLE)
//     busy                   high whenever not IDLE
//     in_valid/in_ready      operand pair handshake, in_a/in_b operands
//     mul_a, mul_b           operands to the multiplier (pass-through)
//     mul_sum/carry/exp/exc  multiplier results for the current operands
//     acc_clear              one-cycle clear pulse to the accumulator
//     acc_valid/acc_ready    product term handshake
//     acc_sign/sum/carry/exp registered product term
//     done                   one-cycle completion pulse
//     done_count, done_exc   pairs consumed and sticky exception, valid with done
//
//   Build option
//     KDOT_ZERO_SKIP_EN      when defined, pairs with a zero operand are counted
//                            but produce no accumulator term.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting operand pairs until remaining reaches 0
//   DRAIN | no more pairs; waiting for the output register to empty
//   DONE  | done pulse, back to IDLE next cycle

module kulisch_dot_ctrl #(
    parameter int DWIDTH = 16,
    parameter int EWIDTH = 5,
    parameter int MWIDTH = 10,
    parameter int LEN_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     in_a,
    input  logic [DWIDTH-1:0]     in_b,
    output logic [DWIDTH-1:0]     mul_a,
    output logic [DWIDTH-1:0]     mul_b,
    input  logic [2*MWIDTH+1:0]   mul_sum,
    input  logic [2*MWIDTH+1:0]   mul_carry,
    input  logic [EWIDTH:0]       mul_exp,
    input  logic                  mul_exc,
    output logic                  acc_clear,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic                  acc_sign,
    output logic [2*MWIDTH+1:0]   acc_sum,
    output logic [2*MWIDTH+1:0]   acc_carry,
    output logic [EWIDTH:0]       acc_exp,
    output logic                  done,
    output logic [LEN_W-1:0]      done_count,
    output logic                  done_exc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic [LEN_W-1:0]     count_q, count_d;
    logic                 exc_q, exc_d;
    logic                 acc_clear_q, acc_clear_d;
    logic                 acc_valid_q, acc_valid_d;
    logic                 acc_sign_q, acc_sign_d;
    logic [2*MWIDTH+1:0]  acc_sum_q, acc_sum_d;
    logic [2*MWIDTH+1:0]  acc_carry_q, acc_carry_d;
    logic [EWIDTH:0]      acc_exp_q, acc_exp_d;

    logic                 in_ready_c;
    logic                 done_c;
    logic                 load_c;
    logic                 drain_ok_c;
    logic                 skip_c;

`ifdef KDOT_ZERO_SKIP_EN
    // A zero operand (exponent and mantissa fields both zero, either sign)
    // contributes nothing to the accumulator, so no term is emitted for it.
    assign skip_c = (in_a[EWIDTH+MWIDTH-1:0] == '0) || (in_b[EWIDTH+MWIDTH-1:0] == '0);
`else
    assign skip_c = 1'b0;
`endif

    // The output register can take a new term (or is about to be empty)
    // when it is empty now or the accumulator takes its term this cycle.
    assign drain_ok_c = !acc_valid_q || acc_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        exc_d       = exc_q;
        acc_clear_d = 1'b0;
        acc_valid_d = acc_valid_q;
        acc_sign_d  = acc_sign_q;
        acc_sum_d   = acc_sum_q;
        acc_carry_d = acc_carry_q;
        acc_exp_d   = acc_exp_q;
        in_ready_c  = 1'b0;
        done_c      = 1'b0;
        load_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = cfg_len;
                    count_d     = '0;
                    exc_d       = 1'b0;
                    acc_clear_d = 1'b1;
                    state_d     = (cfg_len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                in_ready_c = (remaining_q != '0) && drain_ok_c;
                if (in_valid && in_ready_c) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    count_d     = count_q + LEN_W'(1);
                    exc_d       = exc_q | mul_exc;
                    load_c      = !skip_c;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Hold off while the clear pulse is still out so a zero-length
                // run never reports done in the same breath as its clear.
                if (drain_ok_c && !acc_clear_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new term overwrites the one being handed off, so back-to-back
        // terms flow with no bubble.
        if (load_c) begin
            acc_valid_d = 1'b1;
            acc_sign_d  = in_a[DWIDTH-1] ^ in_b[DWIDTH-1];
            acc_sum_d   = mul_sum;
            acc_carry_d = mul_carry;
            acc_exp_d   = mul_exp;
        end else if (acc_ready) begin
            acc_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            exc_q       <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_sign_q  <= 1'b0;
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            acc_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            exc_q       <= exc_d;
            acc_clear_q <= acc_clear_d;
            acc_valid_q <= acc_valid_d;
            acc_sign_q  <= acc_sign_d;
            acc_sum_q   <= acc_sum_d;
            acc_carry_q <= acc_carry_d;
            acc_exp_q   <= acc_exp_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign in_ready   = in_ready_c;
    assign mul_a      = in_a;
    assign mul_b      = in_b;
    assign acc_clear  = acc_clear_q;
    assign acc_valid  = acc_valid_q;
    assign acc_sign   = acc_sign_q;
    assign acc_sum    = acc_sum_q;
    assign acc_carry  = acc_carry_q;
    assign acc_exp    = acc_exp_q;
    assign done       = done_c;
    assign done_count = count_q;
    assign done_exc   = exc_q;

endmodule

// File: tb/tb_kulisch_dot_ctrl.sv
// Bench for kulisch_dot_ctrl: directed scenarios plus randomized runs, checked
// every cycle against a transaction-level model (queue of outstanding terms,
// pair/exception tallies and event cycle numbers), plus literal checks per
// scenario.
module tb_kulisch_dot_ctrl;

    localparam int LEN_W = 8;
`ifdef KDOT_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif
    localparam int NEVER = 32'h4000_0000;

    typedef struct packed {
        logic        sign;
        logic [21:0] sum;
        logic [21:0] carry;
        logic [5:0]  exp;
    } term_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic [21:0] mul_sum = '0, mul_carry = '0;
    logic [5:0]  mul_exp = '0;
    logic        mul_exc = 1'b0;
    logic        acc_ready = 1'b1;

    logic        busy, in_ready, acc_clear, acc_valid, acc_sign, done, done_exc;
    logic [15:0] mul_a, mul_b;
    logic [21:0] acc_sum, acc_carry;
    logic [5:0]  acc_exp;
    logic [7:0]  done_count;

    kulisch_dot_ctrl #(.DWIDTH(16), .EWIDTH(5), .MWIDTH(10), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cfg_len(cfg_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_sum(mul_sum), .mul_carry(mul_carry),
        .mul_exp(mul_exp), .mul_exc(mul_exc), .acc_clear(acc_clear),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_sign(acc_sign),
        .acc_sum(acc_sum), .acc_carry(acc_carry), .acc_exp(acc_exp),
        .done(done), .done_count(done_count), .done_exc(done_exc)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit skip_model(input logic [15:0] a, input logic [15:0] b);
        return ZSKIP && ((a[14:0] == 15'd0) || (b[14:0] == 15'd0));
    endfunction

    // model state
    term_t q[$];
    term_t t_new;
    bit    m_active = 1'b0;
    bit    m_just_reset = 1'b0;
    int    m_len = 0, m_acc = 0;
    bit    m_exc = 1'b0;
    int    m_clear_cyc = -10, m_done_cyc = -10, m_drain_from = NEVER;
    bit    exp_ready, q_empty0, was_active;

    // per-run observations for literal checks
    int    st_terms = 0, st_done = 0, st_clears = 0, st_start_cyc = 0, st_done_lat = 0;
    logic  st_last_sign = 1'b0, st_done_exc = 1'b0;
    logic [7:0] st_done_count = '0;

    always @(negedge CLK) begin
        cyc++;
        exp_ready = m_active && (m_acc < m_len) && (q.size() == 0 || acc_ready);
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_active));
            chk("acc_clear", 64'(acc_clear), 64'(cyc == m_clear_cyc));
            chk("done", 64'(done), 64'(cyc == m_done_cyc));
            chk("acc_valid", 64'(acc_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("mul_a", 64'(mul_a), 64'(in_a));
            chk("mul_b", 64'(mul_b), 64'(in_b));
            if (acc_valid && q.size() != 0) begin
                chk("acc_sign", 64'(acc_sign), 64'(q[0].sign));
                chk("acc_sum", 64'(acc_sum), 64'(q[0].sum));
                chk("acc_carry", 64'(acc_carry), 64'(q[0].carry));
                chk("acc_exp", 64'(acc_exp), 64'(q[0].exp));
            end
            if (cyc == m_done_cyc) begin
                chk("done_count", 64'(done_count), 64'(m_acc % 256));
                chk("done_exc", 64'(done_exc), 64'(m_exc));
            end
            if (m_just_reset) begin
                chk("rst_acc_sign", 64'(acc_sign), 64'd0);
                chk("rst_acc_sum", 64'(acc_sum), 64'd0);
                chk("rst_acc_carry", 64'(acc_carry), 64'd0);
                chk("rst_acc_exp", 64'(acc_exp), 64'd0);
                chk("rst_done_count", 64'(done_count), 64'd0);
                chk("rst_done_exc", 64'(done_exc), 64'd0);
            end
        end

        if (acc_valid && acc_ready) begin
            st_terms++;
            st_last_sign = acc_sign;
        end
        if (acc_clear) st_clears++;
        if (done) begin
            st_done++;
            st_done_count = done_count;
            st_done_exc = done_exc;
            st_done_lat = cyc - st_start_cyc;
        end

        m_just_reset = 1'b0;
        if (RST) begin
            m_active = 1'b0;
            q.delete();
            m_len = 0;
            m_acc = 0;
            m_exc = 1'b0;
            m_clear_cyc = -10;
            m_done_cyc = -10;
            m_drain_from = NEVER;
            m_just_reset = 1'b1;
        end else begin
            q_empty0 = (q.size() == 0);
            was_active = m_active;
            // Completion: once no pairs remain, done follows the cycle the
            // last term leaves (or the register is found empty).
            if (was_active && m_done_cyc < 0 && cyc >= m_drain_from && (q_empty0 || acc_ready))
                m_done_cyc = cyc + 1;
            if (was_active && cyc == m_done_cyc)
                m_active = 1'b0;
            if (!was_active && start) begin
                m_active = 1'b1;
                m_len = int'(cfg_len);
                m_acc = 0;
                m_exc = 1'b0;
                m_clear_cyc = cyc + 1;
                m_done_cyc = -10;
                m_drain_from = (cfg_len == 8'd0) ? cyc + 2 : NEVER;
                st_start_cyc = cyc;
            end
            if (was_active) begin
                if (!q_empty0 && acc_ready) void'(q.pop_front());
                if (in_valid && exp_ready) begin
                    m_acc++;
                    m_exc = m_exc | mul_exc;
                    if (!skip_model(in_a, in_b)) begin
                        t_new.sign = in_a[15] ^ in_b[15];
                        t_new.sum = mul_sum;
                        t_new.carry = mul_carry;
                        t_new.exp = mul_exp;
                        q.push_back(t_new);
                    end
                    if (m_acc == m_len) m_drain_from = cyc + 1;
                end
            end
        end
    end

    logic [15:0] pa [0:255];
    logic [15:0] pb [0:255];
    logic        pexc [0:255];

    task automatic tick(output bit hs);
        @(negedge CLK);
        hs = in_valid && in_ready;
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int len, input bit rv, input bit rr, input int low_at,
                       input bit busy_start, input int rst_after);
        int k, guard, low_cnt;
        bit hs, low_done;
        st_terms = 0; st_done = 0; st_clears = 0; st_done_lat = 0;
        st_done_count = 8'hEE; st_done_exc = 1'b0; st_last_sign = 1'b0;
        cfg_len = 8'(len);
        start = 1'b1;
        in_valid = 1'b0;
        acc_ready = 1'b1;
        tick(hs);
        start = 1'b0;
        k = 0; guard = 0; low_cnt = 0; low_done = 1'b0;
        while (k < len && guard < 2000) begin
            if (rst_after >= 0 && k == rst_after) begin
                RST = 1'b1;
                in_valid = 1'b0;
                tick(hs);
                RST = 1'b0;
                return;
            end
            if (k == low_at && !low_done) begin
                low_cnt = 3;
                low_done = 1'b1;
            end
            in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            in_a = pa[k];
            in_b = pb[k];
            mul_exc = pexc[k];
            mul_sum = 22'($urandom);
            mul_carry = 22'($urandom);
            mul_exp = 6'($urandom);
            acc_ready = (low_cnt > 0) ? 1'b0 : (rr ? 1'($urandom_range(0, 3) != 0) : 1'b1);
            if (low_cnt > 0) low_cnt--;
            start = busy_start && (k == 1);
            tick(hs);
            if (hs) k++;
            guard++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (k < len) chk("pairs_accepted_timeout", 64'(k), 64'(len));
        guard = 0;
        while (st_done == 0 && guard < 200) begin
            acc_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(hs);
            guard++;
        end
        chk("done_seen", 64'(st_done), 64'd1);
        acc_ready = 1'b1;
        tick(hs);
    endtask

    initial begin
        bit hs;
        int len;
        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        tick(hs);
        RST = 1'b0;
        tick(hs);

        // basic run
        pa[0] = 16'h3C00; pb[0] = 16'h4000; pexc[0] = 1'b0;
        pa[1] = 16'h4000; pb[1] = 16'h4000; pexc[1] = 1'b0;
        pa[2] = 16'hBC00; pb[2] = 16'h3C00; pexc[2] = 1'b0;
        run(3, 1'b0, 1'b0, -1, 1'b0, -1);
        chk("basic_terms", 64'(st_terms), 64'd3);
        chk("basic_last_sign", 64'(st_last_sign), 64'd1);
        chk("basic_done_count", 64'(st_done_count), 64'd3);
        chk("basic_done_exc", 64'(st_done_exc), 64'd0);
        chk("basic_clears", 64'(st_clears), 64'd1);

        // backpressure
        pa[3] = 16'h4200; pb[3] = 16'hC000; pexc[3] = 1'b0;
        run(4, 1'b0, 1'b0, 2, 1'b0, -1);
        chk("bp_terms", 64'(st_terms), 64'd4);
        chk("bp_done_count", 64'(st_done_count), 64'd4);

        // zero length, then busy start
        run(0, 1'b0, 1'b0, -1, 1'b0, -1);
        chk("zl_done_lat", 64'(st_done_lat), 64'd3);
        chk("zl_done_count", 64'(st_done_count), 64'd0);
        chk("zl_terms", 64'(st_terms), 64'd0);
        run(4, 1'b0, 1'b0, -1, 1'b1, -1);
        chk("busy_start_clears", 64'(st_clears), 64'd1);
        chk("busy_start_done_count", 64'(st_done_count), 64'd4);

        // exception sticky
        pexc[0] = 1'b1; pexc[1] = 1'b0;
        run(2, 1'b0, 1'b0, -1, 1'b0, -1);
        chk("exc_sticky", 64'(st_done_exc), 64'd1);
        pexc[0] = 1'b0;
        run(2, 1'b0, 1'b0, -1, 1'b0, -1);
        chk("exc_clean", 64'(st_done_exc), 64'd0);

        // zero operand in the middle
        pa[0] = 16'h3C00; pb[0] = 16'h4000;
        pa[1] = 16'h0000; pb[1] = 16'h4000;
        pa[2] = 16'h4000; pb[2] = 16'h3C00;
        run(3, 1'b0, 1'b0, -1, 1'b0, -1);
        chk("zskip_terms", 64'(st_terms), ZSKIP ? 64'd2 : 64'd3);
        chk("zskip_done_count", 64'(st_done_count), 64'd3);

        // reset mid-run
        for (int i = 0; i < 5; i++) begin
            pa[i] = 16'h3C00 + 16'(i); pb[i] = 16'h4000; pexc[i] = 1'b0;
        end
        run(5, 1'b0, 1'b0, -1, 1'b0, 2);
        for (int i = 0; i < 4; i++) tick(hs);
        chk("rst_no_done", 64'(st_done), 64'd0);
        run(3, 1'b0, 1'b0, -1, 1'b0, -1);
        chk("post_rst_done_count", 64'(st_done_count), 64'd3);

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                pa[i] = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
                pb[i] = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
                pexc[i] = ($urandom_range(0, 7) == 0);
            end
            run(len, 1'b1, 1'b1, -1, 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
